// File: rtl/sl_pkg.sv
// rtl/sl_pkg.sv - shared SL line definitions: FSM states, {zeroes,ones} line codes, timing default
package sl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BIT_ACT,
    BIT_GAP,
    STOP_ACT,
    STOP_GAP
  } sl_state_e;

  localparam int SL_HALF_PERIOD = 16;

  // Line codes as {zeroes, ones}; both lines idle high.
  localparam logic [1:0] LINE_IDLE = 2'b11;
  localparam logic [1:0] LINE_ONE  = 2'b10;
  localparam logic [1:0] LINE_ZERO = 2'b01;
  localparam logic [1:0] LINE_STOP = 2'b00;

  // Lengths of 0 or above 32 mean a full 32-bit word.
  function automatic logic [5:0] eff_len(input logic [5:0] len);
    return (len == 6'd0 || len > 6'd32) ? 6'd32 : len;
  endfunction

  function automatic logic [31:0] len_mask(input logic [5:0] len);
    if (len >= 6'd32) return '1;
    return (32'd1 << len) - 32'd1;
  endfunction

  function automatic logic [1:0] bit_code(input logic b);
    return b ? LINE_ONE : LINE_ZERO;
  endfunction

endpackage

// File: rtl/sl_tx_bit_timer.sv
// rtl/sl_tx_bit_timer.sv - phase counter: reload on state change, count down, flag last and next-to-last cycle
module sl_tx_bit_timer
  import sl_pkg::*;
#(
  parameter int HALF_PERIOD = SL_HALF_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire,
  output logic near
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(HALF_PERIOD - 1);
    end else if (en && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expire = en && (cnt == '0);
  // near lets the owner register a pulse that lands on the final cycle of a phase
  assign near   = en && (cnt == CW'(1));

endmodule

// File: rtl/sl_transmitter.sv
// rtl/sl_transmitter.sv - SL word transmitter; SL_TX_ERR_INJECT_EN adds tx_err_inj parity/length fault injection
module sl_transmitter
  import sl_pkg::*;
#(
  parameter int HALF_PERIOD = SL_HALF_PERIOD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [31:0] tx_data,
  input  logic [5:0]  tx_len,
`ifdef SL_TX_ERR_INJECT_EN
  input  logic [1:0]  tx_err_inj,
`endif
  output logic        sl_zeroes_o,
  output logic        sl_ones_o,
  output logic        tx_busy,
  output logic        tx_done
);

  sl_state_e   state;
  logic [32:0] shreg;
  logic [5:0]  bits_left;
  logic [1:0]  line_q;

  logic        load;
  logic        expire;
  logic        near;
  logic [5:0]  len_eff;
  logic [5:0]  n_send;
  logic        parity;
  logic [32:0] frame;

  // Frame holds the data bits to send with the parity bit placed right above them.
  always_comb begin
    len_eff = eff_len(tx_len);
    parity  = ~^(tx_data & len_mask(len_eff));
    n_send  = len_eff;
`ifdef SL_TX_ERR_INJECT_EN
    if (tx_err_inj[1]) n_send = len_eff - 6'd1;
    if (tx_err_inj[0]) parity = ~parity;
`endif
    frame = {1'b0, tx_data & len_mask(n_send)} | ({32'd0, parity} << n_send);
  end

  assign load = (state == IDLE) ? (tx_valid && tx_ready) : expire;

  sl_tx_bit_timer #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .en     (state != IDLE),
    .expire (expire),
    .near   (near)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      line_q    <= LINE_IDLE;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      shreg     <= '0;
      bits_left <= '0;
    end else begin
      tx_done <= (state == STOP_GAP && near) ||
                 (HALF_PERIOD == 1 && state == STOP_ACT && expire);
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg     <= frame;
            bits_left <= n_send + 6'd1;
            line_q    <= bit_code(frame[0]);
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b1;
            state     <= BIT_ACT;
          end
        end
        BIT_ACT: begin
          if (expire) begin
            line_q    <= LINE_IDLE;
            bits_left <= bits_left - 6'd1;
            state     <= BIT_GAP;
          end
        end
        BIT_GAP: begin
          if (expire) begin
            if (bits_left != 6'd0) begin
              shreg  <= shreg >> 1;
              line_q <= bit_code(shreg[1]);
              state  <= BIT_ACT;
            end else begin
              line_q <= LINE_STOP;
              state  <= STOP_ACT;
            end
          end
        end
        STOP_ACT: begin
          if (expire) begin
            line_q <= LINE_IDLE;
            state  <= STOP_GAP;
          end
        end
        STOP_GAP: begin
          if (expire) begin
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          line_q   <= LINE_IDLE;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign sl_zeroes_o = line_q[1];
  assign sl_ones_o   = line_q[0];

endmodule

// File: tb/tb_sl_transmitter.sv
// tb/tb_sl_transmitter.sv - self-checking bench for sl_transmitter against a per-cycle line model
module tb_sl_transmitter;

  localparam int HP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic [5:0]  tx_len;
  logic        sl_zeroes_o;
  logic        sl_ones_o;
  logic        tx_busy;
  logic        tx_done;
`ifdef SL_TX_ERR_INJECT_EN
  logic [1:0]  tx_err_inj;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sl_transmitter #(.HALF_PERIOD(HP)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_len      (tx_len),
`ifdef SL_TX_ERR_INJECT_EN
    .tx_err_inj  (tx_err_inj),
`endif
    .sl_zeroes_o (sl_zeroes_o),
    .sl_ones_o   (sl_ones_o),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_len(input int l);
    return (l == 0 || l > 32) ? 32 : l;
  endfunction

  function automatic int model_nsend(input int l, input logic [1:0] e);
    return e[1] ? model_len(l) - 1 : model_len(l);
  endfunction

  function automatic int word_cycles(input int l, input logic [1:0] e);
    return (model_nsend(l, e) + 2) * 2 * HP;
  endfunction

  // Expected {zeroes,ones} at cycle k after the transfer (k=0 is the first ACT cycle).
  function automatic logic [1:0] exp_code(input logic [31:0] d, input int l, input logic [1:0] e, input int k);
    int len, ns, ones, phase, b;
    logic par;
    len  = model_len(l);
    ns   = model_nsend(l, e);
    ones = 0;
    for (int i = 0; i < len; i++) ones += d[i];
    par   = ((ones % 2) == 0) ^ e[0];
    phase = k / HP;
    b     = phase / 2;
    if (phase % 2 == 1) return 2'b11;
    if (b < ns) return d[b] ? 2'b10 : 2'b01;
    if (b == ns) return par ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic start_word(input logic [31:0] d, input logic [5:0] l, input logic [1:0] e);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!tx_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check_eq("ready_before_send", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = d;
    tx_len   = l;
`ifdef SL_TX_ERR_INJECT_EN
    tx_err_inj = e;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input logic [31:0] d, input logic [5:0] l, input logic [1:0] e,
                            input bit jitter, output int done_at);
    int total;
    total   = word_cycles(int'(l), e);
    done_at = -1;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      check_eq($sformatf("lines d=%08h len=%0d k=%0d", d, l, k), {sl_zeroes_o, sl_ones_o}, exp_code(d, int'(l), e, k));
      check_eq($sformatf("done k=%0d", k), tx_done, (k == total - 1));
      if (k == 0) begin
        check_eq("busy_in_word", tx_busy, 1);
        check_eq("ready_in_word", tx_ready, 0);
      end
      if (tx_done && done_at < 0) done_at = k + 1;
      if (jitter) begin
        tx_valid = (k != total - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        tx_data  = $urandom;
        tx_len   = 6'($urandom_range(0, 63));
`ifdef SL_TX_ERR_INJECT_EN
        tx_err_inj = 2'($urandom_range(0, 3));
`endif
      end
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check_eq({tag, "_ready"}, tx_ready, 1);
    check_eq({tag, "_busy"}, tx_busy, 0);
    check_eq({tag, "_done"}, tx_done, 0);
    check_eq({tag, "_lines"}, {sl_zeroes_o, sl_ones_o}, 2'b11);
  endtask

  task automatic run_word(input string tag, input logic [31:0] d, input logic [5:0] l,
                          input logic [1:0] e, input bit jitter, input int exp_done);
    int done_at;
    start_word(d, l, e);
    tx_valid = jitter ? 1'($urandom_range(0, 1)) : 1'b0;
    check_word(d, l, e, jitter, done_at);
    if (exp_done > 0) check_eq({tag, "_done_cycle"}, done_at, exp_done);
    check_idle(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at;
    int seen_done;
    logic [31:0] d1, d2;
    logic [1:0]  e;

    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 32'hDEAD_BEEF;
    tx_len   = 6'd8;
`ifdef SL_TX_ERR_INJECT_EN
    tx_err_inj = 2'b00;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_lines", {sl_zeroes_o, sl_ones_o}, 2'b11);
    check_eq("reset_ready", tx_ready, 1);
    check_eq("reset_busy", tx_busy, 0);
    check_eq("reset_done", tx_done, 0);
    tx_valid = 1'b0;
    rst      = 1'b0;

    run_word("a5", 32'h0000_00A5, 6'd8, 2'b00, 1'b0, 320);
    run_word("ones32", 32'hFFFF_FFFF, 6'd32, 2'b00, 1'b0, 1088);
    run_word("len0", 32'h0000_0001, 6'd0, 2'b00, 1'b0, 1088);
    run_word("len40", 32'h8000_0003, 6'd40, 2'b00, 1'b0, 1088);
    run_word("len1", 32'hFFFF_FFFE, 6'd1, 2'b00, 1'b0, 96);

    for (int i = 0; i < 6; i++) begin
      e = 2'b00;
`ifdef SL_TX_ERR_INJECT_EN
      e = 2'($urandom_range(0, 3));
`endif
      run_word($sformatf("rand%0d", i), $urandom, 6'($urandom_range(0, 63)), e, 1'b1, -1);
    end

    // back-to-back with tx_valid held high
    d1 = $urandom;
    d2 = $urandom;
    start_word(d1, 6'd4, 2'b00);
    tx_data = d2;
    tx_len  = 6'd3;
    check_word(d1, 6'd4, 2'b00, 1'b0, done_at);
    @(negedge clk);
    check_eq("b2b_gap_ready", tx_ready, 1);
    check_eq("b2b_gap_lines", {sl_zeroes_o, sl_ones_o}, 2'b11);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    check_word(d2, 6'd3, 2'b00, 1'b0, done_at);
    check_eq("b2b_second_done", done_at, 5 * 2 * HP);
    check_idle("b2b_end");

    // reset in the middle of bit 5
    start_word(32'h0000_005A, 6'd8, 2'b00);
    tx_valid = 1'b0;
    for (int k = 0; k < 10 * HP + 3; k++) @(negedge clk);
    check_eq("pre_rst_busy", tx_busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_lines", {sl_zeroes_o, sl_ones_o}, 2'b11);
    check_eq("rst_mid_ready", tx_ready, 1);
    check_eq("rst_mid_busy", tx_busy, 0);
    seen_done = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (tx_done) seen_done++;
    end
    check_eq("rst_mid_no_done", seen_done, 0);

    run_word("after_rst", 32'h0000_00A5, 6'd8, 2'b00, 1'b0, 320);

`ifdef SL_TX_ERR_INJECT_EN
    run_word("inj_par", 32'h0000_00A5, 6'd8, 2'b01, 1'b0, 320);
    run_word("inj_short", 32'h0000_00A5, 6'd8, 2'b10, 1'b0, 288);
    run_word("inj_both", 32'h0000_00A5, 6'd8, 2'b11, 1'b0, 288);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sl_transmitter.md
SL_TRANSMITTER -- requirements
Module: sl_transmitter

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 16: clocks per active phase and per idle phase of one line bit.
REQ-002 SHALL have port clk, input, 1: single clock (16 MHz); all logic on posedge clk.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port tx_valid, input, 1: word request.
REQ-005 SHALL have port tx_ready, output, 1: high only in IDLE; transfer occurs when tx_valid && tx_ready.
REQ-006 SHALL have port tx_data, input, 32: word, LSB sent first.
REQ-007 SHALL have port tx_len, input, 6: data-bit count, sampled with tx_data.
REQ-008 SHALL have port sl_zeroes_o, output, 1: zeroes line, registered, idle high.
REQ-009 SHALL have port sl_ones_o, output, 1: ones line, registered, idle high.
REQ-010 SHALL have port tx_busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port tx_done, output, 1: one-cycle pulse at end of word.

Function
REQ-012 SHALL run FSM states IDLE, BIT_ACT, BIT_GAP, STOP_ACT, STOP_GAP.
REQ-013 SHALL drive line codes as follows: data/parity 1 = ones low, zeroes high; data/parity 0 = zeroes low, ones high; stop = both low; idle/gap = both high.
REQ-014 SHALL, on transfer in cycle N, latch tx_data, tx_len and parity, and enter BIT_ACT with the first bit visible on the lines from cycle N+1.
REQ-015 SHALL hold each ACT state and each GAP state for exactly HALF_PERIOD cycles, counted by a phase counter reloaded on every state change.
REQ-016 SHALL go BIT_ACT->BIT_GAP; from BIT_GAP go to BIT_ACT while bits remain, else to STOP_ACT; then STOP_ACT->STOP_GAP->IDLE.
REQ-017 SHALL send tx_len data bits followed by one parity bit; the parity bit equals ~^data[len-1:0], giving an odd count of ones.
REQ-018 SHALL treat tx_len = 0 or tx_len > 32 as 32.
REQ-019 SHALL make total word time (len+2)*2*HALF_PERIOD cycles from the first ACT cycle to the last STOP_GAP cycle.
REQ-020 SHALL pulse tx_done in the last STOP_GAP cycle; tx_ready SHALL rise the following cycle.
REQ-021 SHALL ignore tx_valid and any tx_data/tx_len changes while busy.
REQ-022 SHALL accept back-to-back words with tx_valid held high, leaving no extra idle beyond STOP_GAP.

Reset
REQ-023 SHALL, when rst is high at a clock edge, force IDLE, sl_zeroes_o=1, sl_ones_o=1, tx_ready=1, tx_busy=0, tx_done=0, and clear counters and shift register.
REQ-024 SHALL, on reset during a word, abort the word with lines high the next cycle and no tx_done pulse.

Configuration
REQ-025 SHALL, with SL_TX_ERR_INJECT_EN defined, add input tx_err_inj[1:0], sampled at transfer: bit0 inverts the parity bit; bit1 sends one fewer data bit (parity still computed over the full word). Both bits may be set together.
REQ-026 SHALL, without SL_TX_ERR_INJECT_EN, omit the port and the associated logic entirely.

Structure
REQ-027 SHALL place the FSM state typedef, the line-code constants (IDLE/ONE/ZERO/STOP as {zeroes,ones} pairs) and the HALF_PERIOD default in shared package sl_pkg, which the receiver also uses.
REQ-028 SHALL implement the phase counter as sub-module sl_tx_bit_timer (load, count, expire pulse).

Verification
REQ-029 SHALL verify: tx_len=8, tx_data=0xA5 -> LSB-first codes 1,0,1,0,0,1,0,1, then parity 1 (four ones), then stop; tx_done at cycle 320 after the first ACT cycle.
REQ-030 SHALL verify: tx_len=32, tx_data=0xFFFFFFFF -> 32 ones, parity 1, stop; 1088 cycles.
REQ-031 SHALL verify: tx_len=0, tx_data=0x0000_0001 -> behaves exactly as tx_len=32.
REQ-032 SHALL verify: two words back-to-back with tx_valid held -> the second word's first ACT cycle immediately follows the cycle after tx_done; no dropped word.
REQ-033 SHALL verify: rst pulsed mid-word at bit 5 -> both lines high next cycle, tx_ready=1, no tx_done.
REQ-034 SHALL verify, with SL_TX_ERR_INJECT_EN: tx_err_inj=01 on 0xA5 -> parity sent as 0; an SL receiver with parity check on flags PEF.
